aes_ctrl_input_stage: RTL and testbench

// Input stage of the AES controller: receives a packet of 32-bit bus words, latches the first word as
// the AES command, and packs the remaining words into 128-bit blocks (key, IV and data) in an internal FIFO.
// The processing stage reads the FIFO over a valid/ready handshake. End of packet is reported via

---
 rtl/aes_ctrl_input_stage_pkg.sv | 31 +++
 rtl/aes_ctrl_input_stage_if.sv | 21 ++
 rtl/aes_ctrl_input_stage_fifo.sv | 36 +++
 rtl/aes_ctrl_input_stage.sv | 63 ++++++
 tb/tb_aes_ctrl_input_stage.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_input_stage_pkg.sv
// aes_ctrl_input_stage_pkg: shared AES widths, FIFO geometry, packer phase and command-field decode helpers.
package aes_ctrl_input_stage_pkg;
  localparam int WORD_S = 32;
  localparam int CMD_BITS = 32;
  localparam int BLK_S = 128;
  localparam int KEY_S = 256;
  localparam int IV_BITS = 128;
  localparam int WORDS_PER_BLK = BLK_S / WORD_S;
  localparam int FIFO_ADDR_WIDTH = 9;
  localparam int FIFO_SIZE = 1 << (FIFO_ADDR_WIDTH - 1);
  localparam int CMD_KEY128 = 0;
  localparam int CMD_CBC = 1;
  localparam int CMD_ENC = 4;
  localparam int CMD_IV_LOAD = 5;
  typedef logic [WORD_S-1:0] word_t;
  typedef logic [BLK_S-1:0] blk_t;
  typedef logic [CMD_BITS-1:0] cmd_t;
  typedef enum logic {PH_CMD, PH_DATA} phase_e;
  function automatic logic is_128bit_key(input cmd_t c);
    return c[CMD_KEY128];
  endfunction
  function automatic logic is_CBC_op(input cmd_t c);
    return c[CMD_CBC];
  endfunction
  function automatic logic is_encryption(input cmd_t c);
    return c[CMD_ENC];
  endfunction
  function automatic logic has_iv(input cmd_t c);
    return c[CMD_IV_LOAD];
  endfunction
endpackage

// File: rtl/aes_ctrl_input_stage_if.sv
// aes_ctrl_input_stage_if: bus-word input and block-FIFO read handshake of the AES controller input stage.
interface aes_ctrl_input_stage_if;
  import aes_ctrl_input_stage_pkg::*;
  logic bus_data_wren;
  logic bus_tlast;
  word_t bus_data;
  logic in_fifo_read_tvalid;
  logic in_fifo_read_tready;
  blk_t in_fifo_rdata;
  logic in_fifo_empty;
  logic controller_in_done;
  logic controller_in_busy;
  modport master (
    output bus_data_wren, bus_tlast, bus_data, in_fifo_read_tready,
    input in_fifo_read_tvalid, in_fifo_rdata, in_fifo_empty, controller_in_done, controller_in_busy
  );
  modport slave (
    input bus_data_wren, bus_tlast, bus_data, in_fifo_read_tready,
    output in_fifo_read_tvalid, in_fifo_rdata, in_fifo_empty, controller_in_done, controller_in_busy
  );
endinterface

// File: rtl/aes_ctrl_input_stage_fifo.sv
// aes_ctrl_input_stage_fifo: synchronous first-word-fall-through block FIFO with wrap-bit pointers.
module aes_ctrl_input_stage_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int SIZE = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] count
);
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic full, do_wr, do_rd;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_WIDTH-2:0] == rd_ptr[ADDR_WIDTH-2:0]) && (wr_ptr[ADDR_WIDTH-1] != rd_ptr[ADDR_WIDTH-1]);
  assign count = wr_ptr - rd_ptr;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  // Head is gated to zero while empty so reset leaves every output at 0.
  assign rdata = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-2:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[ADDR_WIDTH-2:0]] <= wdata;
endmodule

// File: rtl/aes_ctrl_input_stage.sv
// aes_ctrl_input_stage: latches the packet command word and packs following bus words MSB-first into 128-bit FIFO blocks.
module aes_ctrl_input_stage
  import aes_ctrl_input_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  aes_ctrl_input_stage_if.slave  bus,
  output cmd_t                   aes_cmd
);
  phase_e phase;
  logic [1:0] idx;
  blk_t acc, blk;
  logic done, busy, empty, accept, wr;
  logic [FIFO_ADDR_WIDTH-1:0] count;
  // Busy leaves one spare entry so a block completing in the same cycle never meets a full FIFO.
  assign busy = done || (count > FIFO_ADDR_WIDTH'(FIFO_SIZE - 2));
  assign accept = bus.bus_data_wren && !busy;
  assign wr = accept && (phase == PH_DATA) && (idx == 2'd3 || bus.bus_tlast);
  for (genvar w = 0; w < WORDS_PER_BLK; w++) begin : g_word
    assign blk[BLK_S-1-WORD_S*w -: WORD_S] = (2'(w) < idx) ? acc[BLK_S-1-WORD_S*w -: WORD_S] :
                                             (2'(w) == idx) ? bus.bus_data : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phase <= PH_CMD;
      idx <= '0;
      acc <= '0;
      done <= 1'b0;
      aes_cmd <= '0;
    end else begin
      if (done && empty) done <= 1'b0;
      if (accept && phase == PH_CMD) begin
        aes_cmd <= bus.bus_data;
        phase <= bus.bus_tlast ? PH_CMD : PH_DATA;
        done <= bus.bus_tlast;
      end else if (accept) begin
        acc[{~idx, 5'b0} +: WORD_S] <= bus.bus_data;
        idx <= wr ? 2'd0 : idx + 2'd1;
        if (bus.bus_tlast) begin
          phase <= PH_CMD;
          done <= 1'b1;
        end
      end
    end
  aes_ctrl_input_stage_fifo #(
    .DATA_WIDTH(BLK_S),
    .ADDR_WIDTH(FIFO_ADDR_WIDTH),
    .SIZE(FIFO_SIZE)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr),
    .wdata(blk),
    .rd_en(bus.in_fifo_read_tready),
    .rdata(bus.in_fifo_rdata),
    .empty(empty),
    .count(count)
  );
  assign bus.in_fifo_empty = empty;
  assign bus.in_fifo_read_tvalid = !empty;
  assign bus.controller_in_done = done;
  assign bus.controller_in_busy = busy;
endmodule

// File: tb/tb_aes_ctrl_input_stage.sv
// tb_aes_ctrl_input_stage: directed-vector self-checking bench for the AES controller input stage.
module tb_aes_ctrl_input_stage;
  import aes_ctrl_input_stage_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  cmd_t aes_cmd;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  aes_ctrl_input_stage_if bus ();
  aes_ctrl_input_stage dut (.clk(clk), .reset(reset), .bus(bus), .aes_cmd(aes_cmd));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input word_t d, input logic last);
    bus.bus_data_wren = 1'b1;
    bus.bus_data = d;
    bus.bus_tlast = last;
    tick();
    bus.bus_data_wren = 1'b0;
    bus.bus_tlast = 1'b0;
  endtask
  task automatic pop(input string tag, input blk_t exp);
    check({tag, "_tvalid"}, bus.in_fifo_read_tvalid, 1'b1);
    check({tag, "_rdata"}, bus.in_fifo_rdata, exp);
    bus.in_fifo_read_tready = 1'b1;
    tick();
    bus.in_fifo_read_tready = 1'b0;
  endtask
  task automatic wait_ready();
    for (int n = 0; n < 2000 && bus.controller_in_busy; n++) tick();
    check("wait_busy_low", bus.controller_in_busy, 1'b0);
  endtask
  function automatic word_t wd(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction
  function automatic blk_t bk(input int b);
    return {wd(4*b), wd(4*b+1), wd(4*b+2), wd(4*b+3)};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.bus_data_wren = 1'b0;
    bus.bus_tlast = 1'b0;
    bus.bus_data = '0;
    bus.in_fifo_read_tready = 1'b0;
    #12;
    check("rst_flags", {bus.in_fifo_read_tvalid, bus.in_fifo_empty, bus.controller_in_done, bus.controller_in_busy}, 4'b0100);
    check("rst_rdata", bus.in_fifo_rdata, '0);
    check("rst_cmd", aes_cmd, '0);
    @(negedge clk) reset = 1'b1;
    tick();
    put(32'h11, 1'b0);
    check("t1_cmd", aes_cmd, 32'h11);
    put(32'h0011_2233, 1'b0);
    put(32'h4455_6677, 1'b0);
    put(32'h8899_aabb, 1'b0);
    check("t1_done_early", bus.controller_in_done, 1'b0);
    put(32'hccdd_eeff, 1'b1);
    check("t1_done", bus.controller_in_done, 1'b1);
    check("t1_busy", bus.controller_in_busy, 1'b1);
    pop("t1_blk", 128'h00112233_44556677_8899aabb_ccddeeff);
    check("t1_empty", {bus.in_fifo_empty, bus.controller_in_done}, 2'b11);
    tick();
    check("t1_clear", {bus.controller_in_done, bus.controller_in_busy}, 2'b00);
    put(32'h22, 1'b0);
    for (int i = 0; i < 6; i++) put(32'h1000 + 32'(i), i == 5);
    check("t2_done", bus.controller_in_done, 1'b1);
    pop("t2_b0", {32'h1000, 32'h1001, 32'h1002, 32'h1003});
    pop("t2_b1", {32'h1004, 32'h1005, 64'h0});
    check("t2_empty", {bus.in_fifo_empty, bus.in_fifo_read_tvalid, bus.controller_in_done}, 3'b101);
    tick();
    check("t2_clear", {bus.controller_in_done, bus.controller_in_busy}, 2'b00);
    put(32'h33, 1'b0);
    put(32'h2000, 1'b1);
    put(32'hDEAD, 1'b0);
    check("t6_cmd_kept", aes_cmd, 32'h33);
    pop("t6_blk", {32'h2000, 96'h0});
    check("t6_empty", bus.in_fifo_empty, 1'b1);
    tick();
    put(32'h44, 1'b1);
    check("t6_cmd2", aes_cmd, 32'h44);
    check("t6_cmd_only", {bus.in_fifo_read_tvalid, bus.controller_in_done}, 2'b01);
    tick();
    check("t6_clear", bus.controller_in_done, 1'b0);
    put(32'h55, 1'b0);
    for (int i = 0; i < 7; i++) put(32'h3000 + 32'(i), 1'b0);
    check("t4_head_a", bus.in_fifo_rdata, {32'h3000, 32'h3001, 32'h3002, 32'h3003});
    bus.bus_data_wren = 1'b1;
    bus.bus_data = 32'h3007;
    bus.in_fifo_read_tready = 1'b1;
    tick();
    bus.bus_data_wren = 1'b0;
    bus.in_fifo_read_tready = 1'b0;
    check("t4_tvalid", bus.in_fifo_read_tvalid, 1'b1);
    put(32'h3008, 1'b1);
    pop("t4_b", {32'h3004, 32'h3005, 32'h3006, 32'h3007});
    pop("t4_c", {32'h3008, 96'h0});
    check("t4_empty", bus.in_fifo_empty, 1'b1);
    tick();
    put(32'h66, 1'b0);
    for (int k = 0; k < 1020; k++) put(wd(k), 1'b0);
    check("t3_busy_full", {bus.controller_in_busy, bus.controller_in_done, bus.in_fifo_read_tvalid}, 3'b101);
    put(32'hBAD0_BAD0, 1'b0);
    pop("t3_first", bk(0));
    check("t3_busy_drop", bus.controller_in_busy, 1'b0);
    wait_ready();
    for (int k = 1020; k < 1024; k++) put(wd(k), k == 1023);
    check("t3_done", bus.controller_in_done, 1'b1);
    for (int b = 1; b < 256; b++) pop("t3_drain", bk(b));
    check("t3_empty", bus.in_fifo_empty, 1'b1);
    tick();
    check("t3_clear", bus.controller_in_done, 1'b0);
    put(32'h77, 1'b0);
    put(32'h4000, 1'b0);
    put(32'h4001, 1'b0);
    #3 reset = 1'b0;
    #1;
    check("t5_rst_flags", {bus.in_fifo_read_tvalid, bus.in_fifo_empty, bus.controller_in_done, bus.controller_in_busy}, 4'b0100);
    check("t5_rst_cmd", aes_cmd, '0);
    @(negedge clk) reset = 1'b1;
    tick();
    put(32'h88, 1'b0);
    check("t5_cmd", aes_cmd, 32'h88);
    for (int i = 0; i < 4; i++) put(32'h5000 + 32'(i), i == 3);
    pop("t5_blk", {32'h5000, 32'h5001, 32'h5002, 32'h5003});
    check("t5_empty", bus.in_fifo_empty, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
